// File: rtl/display_pkg.sv
// Shared glyph table and output polarity helper for the display scan block.
package display_pkg;

  // Active-high segment patterns, bit 6 = a down to bit 0 = g.
  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b1110110,  // N
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  // Maps an active-high vector (up to 8 bits) to pin polarity.
  function automatic logic [7:0] pol8(input logic [7:0] v, input bit inv);
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational 4-bit code to active-high 7-segment glyph (bit 6 = a).
module hex7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Plain table lookup.
  always_comb seg = GLYPH_TBL[bcd];

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scanner: shadowed digit data, per-slot anti-ghost
// blanking, leading-zero suppression and per-digit blink.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] in_bcd,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [0:6]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]               pcnt;
  logic [IW-1:0]               idx;
  logic [FW-1:0]               fcnt;
  logic                        bph;
  logic [N_DIGITS-1:0][3:0]    sh_bcd;
  logic [N_DIGITS-1:0]         sh_dp;
  logic [N_DIGITS-1:0]         sh_blink;
  logic                        slot_end;
  logic                        wrap;

  assign slot_end = (pcnt == PW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx == IW'(N_DIGITS - 1));

  // Shadow capture; load is honoured any cycle, not only at slot boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bcd   <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
    end else if (load) begin
      sh_bcd   <= in_bcd;
      sh_dp    <= dp_in;
      sh_blink <= blink_en;
    end
  end

  // Slot prescaler, digit index and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= slot_end ? '0 : pcnt + 1'b1;
      frame_done <= wrap;
      if (slot_end) idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // Frame counter; blink phase flips every BLINK_FRAMES frames, starting lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      bph  <= 1'b1;
    end else if (wrap) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt <= '0;
        bph  <= ~bph;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Per-digit glyph and dark decision; lz[k] means digits N-1..k are all zero.
  logic [N_DIGITS-1:0][6:0] glyph;
  logic [N_DIGITS-1:0][6:0] lit_seg;
  logic [N_DIGITS-1:0]      lit_dp;
  logic [N_DIGITS-1:0]      lz;
  logic [N_DIGITS-1:0]      dark;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    hex7_decode u_dec (.bcd(sh_bcd[k]), .seg(glyph[k]));

    if (k == N_DIGITS - 1) begin : g_top
      assign lz[k] = (sh_bcd[k] == 4'd0);
    end else begin : g_low
      assign lz[k] = lz[k+1] && (sh_bcd[k] == 4'd0);
    end

    if (k == 0) begin : g_d0
      assign dark[k] = sh_blink[k] && !bph;
    end else begin : g_dn
      assign dark[k] = (blank_lz && lz[k]) || (sh_blink[k] && !bph);
    end

    assign lit_seg[k] = dark[k] ? 7'd0 : glyph[k];
    assign lit_dp[k]  = !dark[k] && sh_dp[k];
  end

  logic [N_DIGITS-1:0] onehot;
  assign onehot = N_DIGITS'(1) << idx;

  // Output registers; polarity is applied only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= N_DIGITS'(pol8(8'd0, AN_ACTIVE_LOW));
      seg <= 7'(pol8(8'd0, SEG_ACTIVE_LOW));
      dp  <= SEG_ACTIVE_LOW;
    end else begin
      an  <= (pcnt < PW'(BLANK_CYCLES)) ? N_DIGITS'(pol8(8'd0, AN_ACTIVE_LOW))
                                        : N_DIGITS'(pol8(8'(onehot), AN_ACTIVE_LOW));
      seg <= 7'(pol8(8'(lit_seg[idx]), SEG_ACTIVE_LOW));
      dp  <= lit_dp[idx] ^ SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short-period configuration.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_bcd;
  logic [3:0]  dp_in;
  logic [3:0]  blink_en;
  logic        blank_lz;
  logic        load;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected shadow contents as the bench understands them.
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic [3:0]  m_blink;
  logic [6:0]  gly [16];

  display_scan_ctrl #(
    .N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_bcd(in_bcd), .dp_in(dp_in),
    .blink_en(blink_en), .blank_lz(blank_lz), .load(load),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs after edge number cyc reflect scan state cyc-1.
  task automatic tick();
    int s, ix, pc;
    logic bph, lzv, dark;
    logic [3:0] an_e, d;
    @(posedge clk);
    #1;
    cyc++;
    s    = cyc - 1;
    ix   = (s / 4) % 4;
    pc   = s % 4;
    bph  = ((s / 32) % 2) == 0;
    an_e = (pc < 1) ? 4'b0000 : 4'(1 << ix);
    lzv  = 1'b1;
    for (int k = 3; k >= ix; k--) if (m_bcd[4*k +: 4] != 4'd0) lzv = 1'b0;
    dark = (blank_lz && ix > 0 && lzv) || (m_blink[ix] && !bph);
    d    = m_bcd[4*ix +: 4];
    chk("an", 32'(an), 32'(an_e));
    chk("frame_done", 32'(frame_done), 32'(cyc % 16 == 0));
    if (an_e != 4'b0000) begin
      chk("seg", 32'(seg), 32'(dark ? 7'd0 : gly[d]));
      chk("dp", 32'(dp), 32'(!dark && m_dp[ix]));
    end
    if (load) begin
      m_bcd   = in_bcd;
      m_dp    = dp_in;
      m_blink = blink_en;
    end
  endtask

  initial begin
    gly[0]  = 7'b1111110; gly[1]  = 7'b0110000; gly[2]  = 7'b1101101; gly[3]  = 7'b1111001;
    gly[4]  = 7'b0110011; gly[5]  = 7'b1011011; gly[6]  = 7'b1011111; gly[7]  = 7'b1110000;
    gly[8]  = 7'b1111111; gly[9]  = 7'b1111011; gly[10] = 7'b1110111; gly[11] = 7'b1110110;
    gly[12] = 7'b1001110; gly[13] = 7'b0111101; gly[14] = 7'b1001111; gly[15] = 7'b1000111;
    m_bcd = '0; m_dp = '0; m_blink = '0;
    in_bcd = 16'h1234; dp_in = 4'b0100; blink_en = 4'b0000; blank_lz = 1'b0; load = 1'b0;

    // Held in reset: everything inactive.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);

    // Load 1234 on the first edge after release; digit 0 appears two clocks in.
    rst_n = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("d0_an_first", 32'(an), 32'h1);
    chk("d0_glyph4_bcfg", 32'(seg), 32'(7'b0110011));
    while (cyc < 32) tick();
    chk("fd_second_frame", 32'(frame_done), 32'd1);

    // Leading-zero blanking, then all-zero value.
    in_bcd = 16'h0070; blank_lz = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (16) tick();
    in_bcd = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (16) tick();

    // Blink digit 0 across several phase flips.
    blank_lz = 1'b0; in_bcd = 16'h5678; blink_en = 4'b0001; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (80) tick();

    // Mid-slot load while digit 2 is showing (idx=2, pcnt=2).
    blink_en = 4'b0000; in_bcd = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    while (cyc % 16 != 10) tick();
    in_bcd = 16'h0A00; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("midslot_an", 32'(an), 32'h4);
    chk("midslot_glyphA", 32'(seg), 32'(7'b1110111));
    repeat (4) tick();

    // Asynchronous reset mid-frame.
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'd0);
    chk("async_seg", 32'(seg), 32'd0);
    chk("async_dp", 32'(dp), 32'd0);
    chk("async_fd", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    chk("hold_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    cyc = 0; m_bcd = '0; m_dp = '0; m_blink = '0;
    repeat (16) tick();
    chk("fd_16_after_release", 32'(frame_done), 32'd1);
    repeat (17) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot, minimum 4.
REQ-003 SHALL have parameter BLANK_CYCLES, default 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be less than REFRESH_DIV.
REQ-004 SHALL have parameter BLINK_FRAMES, default 64: full scan frames per blink half-period.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means the seg and dp outputs are inverted.
REQ-006 SHALL have parameter AN_ACTIVE_LOW, default 1: 1 means the an output is inverted.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port in_bcd, input, 4*N_DIGITS bits: digit codes; digit 0 is bits [3:0] and is the least significant digit.
REQ-010 SHALL have port dp_in, input, N_DIGITS bits: decimal point per digit.
REQ-011 SHALL have port blink_en, input, N_DIGITS bits: per-digit blink enable.
REQ-012 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-013 SHALL have port load, input, 1 bit: capture in_bcd, dp_in and blink_en into shadow registers.
REQ-014 SHALL have port seg, output, [0:6]: segment drive, with seg[0] = a through seg[6] = g.
REQ-015 SHALL have port dp, output, 1 bit: decimal point drive.
REQ-016 SHALL have port an, output, N_DIGITS bits: anode enables, one-hot or all off.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-018 SHALL, when load is 1 at a clock edge, copy in_bcd, dp_in and blink_en into the shadow registers; only shadow values drive the display, and load takes effect in the cycle it is sampled, mid-slot included.
REQ-019 SHALL run prescaler pcnt over 0..REFRESH_DIV-1; when pcnt reaches REFRESH_DIV-1, pcnt returns to 0 and digit index idx advances, wrapping from N_DIGITS-1 to 0.
REQ-020 SHALL pulse frame_done for exactly one cycle, coincident with the cycle in which idx wraps to 0.
REQ-021 SHALL drive an all-inactive while pcnt < BLANK_CYCLES, and otherwise drive only bit idx active.
REQ-022 SHALL decode glyphs (lit segments) as: 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, 10 A abcefg, 11 N abcef, 12 C adef, 13 d bcdeg, 14 E adefg, 15 F aefg.
REQ-023 SHALL treat digit k as a leading zero when blank_lz = 1, k > 0, and shadow digits N_DIGITS-1 down to k are all 0; digit 0 is never blanked.
REQ-024 SHALL run frame counter fcnt over 0..BLINK_FRAMES-1, advancing on frame_done; on wrap, blink phase bph toggles.
REQ-025 SHALL blank a digit (all segments and dp off) when it is a leading zero, or when its blink_en is 1 and bph = 0; an still follows REQ-021.
REQ-026 SHALL register seg, dp and an, so they reflect idx and pcnt with exactly one cycle of latency.
REQ-027 SHALL apply the polarity parameters at the output registers only, with no effect on internal state.

Reset
REQ-028 SHALL, while rst_n = 0, asynchronously force pcnt = 0, idx = 0, fcnt = 0, bph = 1, shadow = 0, and frame_done = 0.
REQ-029 SHALL, while rst_n = 0, force an, seg and dp to their inactive levels.
REQ-030 SHALL, on rst_n release, first drive digit 0 after BLANK_CYCLES+1 clocks.
REQ-031 SHALL, when reset is asserted mid-slot, reset immediately with no partial pulse on frame_done.

Structure
REQ-032 SHALL place the 16-entry glyph table constant and the polarity helper in shared package display_pkg.
REQ-033 SHALL implement glyph lookup as combinational sub-module hex7_decode (4-bit in, 7-bit active-high out).
REQ-034 SHALL size counters with $clog2 of their terminal values.

Verification (N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2, both polarities 0)
REQ-035 SHALL cover: load in_bcd=16'h1234 -> an sequence 0000, 0001 x3, 0000, 0010 x3, ...; seg for digit 0 = glyph 4 = bcfg.
REQ-036 SHALL cover: free-running scan -> frame_done high exactly one cycle every 16 cycles, coincident with idx wrap.
REQ-037 SHALL cover: in_bcd=16'h0070, blank_lz=1 -> digits 3 and 2 blank, digit 1 shows abc, digit 0 shows abcdef; in_bcd=16'h0000 -> only digit 0 lit.
REQ-038 SHALL cover: blink_en=4'b0001 -> digit 0 dark for 2 frames then lit for 2 frames, repeating; other digits always lit.
REQ-039 SHALL cover: load asserted while idx=2 with pcnt=2 -> new value visible at the next registered output, no glitch on an.
REQ-040 SHALL cover: rst_n pulsed low mid-frame -> outputs inactive asynchronously; after release, frame_done first pulses 16 cycles later.
